ray_generator_folded: RTL and testbench
=======================================

Name: ray_generator_folded

Overview:
Multi-cycle ("folded") primary-ray generator for the ray-marching renderer. It takes a pixel coordinate and the camera forward vector, builds a camera basis, and returns a unit ray direction. One fixed-point multiplier and one inverse-square-root unit are time-shared across the sequence. It sits between the ray unit's setup state and the march loop; sdf_query is a separate block.

Parameters:
DISPLAY_WIDTH, 320, active pixels per line (W)
DISPLAY_HEIGHT, 240, active lines (H)
H_BITS, 9, width of the hcount_in port
V_BITS, 8, width of the vcount_in port

Ports:
clk_in  input  1  single system clock
rst_in  input  1  reset, asynchronous and active-low
valid_in  input  1  start request; accepted only when ready_out=1
hcount_in  input  H_BITS  pixel column; captured, not used in arithmetic
vcount_in  input  V_BITS  pixel row; captured, not used in arithmetic
hcount_fp_in  input  fp  pixel column as fp (shared package)
vcount_fp_in  input  fp  pixel row as fp
cam_forward_in  input  vec3  camera forward vector f; unit length; fx, fz not both 0
ray_direction_out  output  vec3  normalized ray direction; held until the next result
valid_out  output  1  one-cycle pulse when ray_direction_out updates
ready_out  output  1  high only in IDLE

Behaviour:
- Number format: fp is signed 32-bit Q16.16 and vec3 is {x,y,z} of fp, both from the shared package. Products are computed at full 64 bits, then arithmetic-shifted right by 16 and truncated.
- Reset (rst_in=0, asynchronous): state is IDLE, ready_out=1, valid_out=0, ray_direction_out=0. An in-flight computation is discarded and produces no valid_out.
- Capture: on a clock edge with valid_in=1 and ready_out=1, latch all inputs and leave IDLE. valid_in is ignored while busy.
- Compute sequence, one multiply per cycle:
  - INV_H = round(65536/H), an elaboration-time constant.
  - u = (hcount_fp − W/2)·INV_H
  - v = (H/2 − vcount_fp)·INV_H
  - r = (fz, 0, −fx)
  - up = (−fx·fy, fx²+fz², −fy·fz)
  - d = f + u·r + v·up
  - out = d · invsqrt(d·d)
- invsqrt:
  - Normalize the argument into [1,4) by an even leading-zero shift.
  - Seed with a constant, then run 3 Newton iterations, y ← y·(1.5 − 0.5·x·y²).
  - Denormalize by half the shift.
  - Result relative error must not exceed 2^-12.
- States: IDLE → UV → BASIS → COMBINE → DOT → INVSQRT → SCALE → DONE → IDLE. Step counters live inside each state.
- Latency is a fixed constant of at most 64 cycles from capture to valid_out, independent of the data.
- DONE: register ray_direction_out, pulse valid_out for 1 cycle, and set ready_out=1 in the following cycle.
- Back-to-back: a valid_in in the first IDLE cycle after DONE is accepted.
- Degenerate d·d=0 (unreachable for legal inputs): output 0 and still pulse valid_out.

Decomposition:
- Shared package: fp, vec3, FP constants (FP_ZERO, FP_HALF, FP_ONE, FP_ONE_POINT_FIVE), fp_mul, fp_add, fp_sub helpers.
- One sub-module: fp_inv_sqrt, a sequential Newton unit with a start/done handshake that reuses the parent's multiplier through a mux, or has its own.
- sdf_query is a separate block with its own spec.

Test Plan:
- f=(0,0,1), pixel (160,120) → out (0,0,1) ±2^-11 per component; valid_out exactly 1 cycle; ready_out low while busy.
- f=(0,0,1), pixel (0,120) → (−0.5547, 0, 0.8321) ±2^-11.
- f=(0,0,1), pixel (160,0) → (0, 0.4472, 0.8944) ±2^-11.
- f=(1,0,0), pixel (0,120) → (0.8321, 0, 0.5547) ±2^-11; |out|² within 2^-10 of 1.
- Second valid_in with a different pixel asserted mid-computation → ignored; first result unchanged; latency identical across all runs.
- rst_in pulsed low mid-computation → ready_out=1 and valid_out=0 immediately; no valid_out follows; a new request afterwards completes correctly.

Source files
------------

// File: rtl/ray_generator_folded_pkg.sv
// Shared fixed-point types and helpers for the ray generator.
// fp is signed Q16.16 and vec3 is {x, y, z} of fp.
package ray_generator_folded_pkg;

  typedef logic signed [31:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  typedef enum logic [2:0] {
    IDLE,
    UV,
    BASIS,
    COMBINE,
    DOT,
    INVSQRT,
    SCALE,
    DONE
  } state_t;

  localparam fp FP_ZERO           = 32'sh0000_0000;
  localparam fp FP_HALF           = 32'sh0000_8000;
  localparam fp FP_ONE            = 32'sh0001_0000;
  localparam fp FP_ONE_POINT_FIVE = 32'sh0001_8000;

  // Full 64-bit product, arithmetic shift by 16, truncate back to Q16.16.
  function automatic fp fp_mul(input fp a, input fp b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return fp'(p >>> 16);
  endfunction

  function automatic fp fp_add(input fp a, input fp b);
    return a + b;
  endfunction

  function automatic fp fp_sub(input fp a, input fp b);
    return a - b;
  endfunction

endpackage

// File: rtl/ray_generator_folded_fp_inv_sqrt.sv
// Sequential Newton-Raphson 1/sqrt(x) on Q16.16 with a start/done handshake.
// Fixed latency; non-positive arguments return 0.
module fp_inv_sqrt
  import ray_generator_folded_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  fp    arg,
  output logic done,
  output fp    result
);

  // Internal math is unsigned Q2.30 so the normalized mantissa in [1,4) keeps full precision.
  localparam logic [31:0] Q30_ONE_POINT_FIVE = 32'h6000_0000;
  localparam logic [31:0] SEED_LO            = 32'h3666_6666;  // 0.85 for m in [1,2)
  localparam logic [31:0] SEED_HI            = 32'h2666_6666;  // 0.60 for m in [2,4)

  logic [31:0] arg_u;
  logic [4:0]  lead;
  logic [4:0]  sh;
  logic [31:0] m_norm;
  logic        busy;
  logic [1:0]  iter;
  logic [1:0]  phase;
  logic [31:0] m, y, y2, t, h;
  logic [4:0]  osh;
  logic        zero;
  logic [31:0] mul_a, mul_b, prod;

  assign arg_u = arg;

  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (arg_u[i]) lead = i[4:0];
    end
  end

  // Even shift putting the leading one at bit 30 or 31; result is undone by half of it.
  assign sh     = (5'd31 - lead) & 5'b11110;
  assign m_norm = arg_u << sh;
  assign h      = Q30_ONE_POINT_FIVE - (t >> 1);

  always_comb begin
    mul_a = y;
    mul_b = y;
    case (phase)
      2'd1:    begin mul_a = m; mul_b = y2; end
      2'd2:    begin mul_a = y; mul_b = h;  end
      default: begin mul_a = y; mul_b = y;  end
    endcase
  end

  assign prod = 32'((64'(mul_a) * 64'(mul_b)) >> 30);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= FP_ZERO;
      busy   <= 1'b0;
      iter   <= '0;
      phase  <= '0;
      m      <= '0;
      y      <= '0;
      y2     <= '0;
      t      <= '0;
      osh    <= '0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        iter  <= '0;
        phase <= '0;
        m     <= m_norm;
        y     <= m_norm[31] ? SEED_HI : SEED_LO;
        osh   <= 5'd21 - {1'b0, sh[4:1]};
        zero  <= (arg <= FP_ZERO);
      end else if (busy) begin
        if (iter == 2'd3) begin
          result <= zero ? FP_ZERO : fp'(y >> osh);
          done   <= 1'b1;
          busy   <= 1'b0;
        end else begin
          case (phase)
            2'd0: begin
              y2    <= prod;
              phase <= 2'd1;
            end
            2'd1: begin
              t     <= prod;
              phase <= 2'd2;
            end
            default: begin
              y     <= prod;
              phase <= 2'd0;
              iter  <= iter + 2'd1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/ray_generator_folded.sv
// Folded primary-ray generator: builds a camera basis from the forward vector
// and returns a normalized ray direction, one shared multiply per cycle.
module ray_generator_folded
  import ray_generator_folded_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  input  logic [H_BITS-1:0] hcount_in,
  input  logic [V_BITS-1:0] vcount_in,
  input  fp                 hcount_fp_in,
  input  fp                 vcount_fp_in,
  input  vec3               cam_forward_in,
  output vec3               ray_direction_out,
  output logic              valid_out,
  output logic              ready_out
);

  localparam fp INV_H  = fp'((65536 + DISPLAY_HEIGHT / 2) / DISPLAY_HEIGHT);
  localparam fp HALF_W = fp'((DISPLAY_WIDTH / 2) * 65536);
  localparam fp HALF_H = fp'((DISPLAY_HEIGHT / 2) * 65536);

  state_t state, next_state;
  logic [2:0] step;

  fp fx, fy, fz, hfp, vfp, u, v;
  fp up_x, up_y, up_z, dx, dy, dz, dd, res_x, res_y;
  fp mul_a, mul_b, prod, inv;
  logic isq_start, isq_done;
  logic [H_BITS-1:0] hcount_q;
  logic [V_BITS-1:0] vcount_q;
  logic unused_pix;

  assign unused_pix = ^{hcount_q, vcount_q};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= next_state;
      // INVSQRT parks at step 1 so the start pulse fires exactly once.
      if (next_state != state) step <= '0;
      else if (state == INVSQRT) step <= 3'd1;
      else step <= step + 3'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (valid_in)      next_state = UV;
      UV:      if (step == 3'd1)  next_state = BASIS;
      BASIS:   if (step == 3'd3)  next_state = COMBINE;
      COMBINE: if (step == 3'd4)  next_state = DOT;
      DOT:     if (step == 3'd2)  next_state = INVSQRT;
      INVSQRT: if (isq_done)      next_state = SCALE;
      SCALE:   if (step == 3'd2)  next_state = DONE;
      default:                    next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_out = (state == IDLE);
    valid_out = (state == DONE);
    isq_start = (state == INVSQRT) && (step == 3'd0);
    mul_a     = FP_ZERO;
    mul_b     = FP_ZERO;
    case (state)
      UV: begin
        mul_a = (step == 3'd0) ? fp_sub(hfp, HALF_W) : fp_sub(HALF_H, vfp);
        mul_b = INV_H;
      end
      BASIS: begin
        case (step)
          3'd0:    begin mul_a = fx; mul_b = fy; end
          3'd1:    begin mul_a = fx; mul_b = fx; end
          3'd2:    begin mul_a = fz; mul_b = fz; end
          default: begin mul_a = fy; mul_b = fz; end
        endcase
      end
      COMBINE: begin
        case (step)
          3'd0:    begin mul_a = u; mul_b = fz;   end
          3'd1:    begin mul_a = v; mul_b = up_x; end
          3'd2:    begin mul_a = v; mul_b = up_y; end
          3'd3:    begin mul_a = u; mul_b = fx;   end
          default: begin mul_a = v; mul_b = up_z; end
        endcase
      end
      DOT: begin
        case (step)
          3'd0:    begin mul_a = dx; mul_b = dx; end
          3'd1:    begin mul_a = dy; mul_b = dy; end
          default: begin mul_a = dz; mul_b = dz; end
        endcase
      end
      SCALE: begin
        case (step)
          3'd0:    begin mul_a = dx; mul_b = inv; end
          3'd1:    begin mul_a = dy; mul_b = inv; end
          default: begin mul_a = dz; mul_b = inv; end
        endcase
      end
      default: ;
    endcase
  end

  assign prod = fp_mul(mul_a, mul_b);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fx <= FP_ZERO; fy <= FP_ZERO; fz <= FP_ZERO;
      hfp <= FP_ZERO; vfp <= FP_ZERO; u <= FP_ZERO; v <= FP_ZERO;
      up_x <= FP_ZERO; up_y <= FP_ZERO; up_z <= FP_ZERO;
      dx <= FP_ZERO; dy <= FP_ZERO; dz <= FP_ZERO; dd <= FP_ZERO;
      res_x <= FP_ZERO; res_y <= FP_ZERO;
      hcount_q <= '0;
      vcount_q <= '0;
      ray_direction_out <= '0;
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          fx <= cam_forward_in.x;
          fy <= cam_forward_in.y;
          fz <= cam_forward_in.z;
          // d starts at f; the u*r and v*up terms accumulate onto it.
          dx <= cam_forward_in.x;
          dy <= cam_forward_in.y;
          dz <= cam_forward_in.z;
          hfp <= hcount_fp_in;
          vfp <= vcount_fp_in;
          hcount_q <= hcount_in;
          vcount_q <= vcount_in;
        end
        UV: if (step == 3'd0) u <= prod; else v <= prod;
        BASIS: begin
          case (step)
            3'd0:    up_x <= -prod;
            3'd1:    up_y <= prod;
            3'd2:    up_y <= fp_add(up_y, prod);
            default: up_z <= -prod;
          endcase
        end
        COMBINE: begin
          case (step)
            3'd0, 3'd1: dx <= fp_add(dx, prod);
            3'd2:       dy <= fp_add(dy, prod);
            3'd3:       dz <= fp_sub(dz, prod);
            default:    dz <= fp_add(dz, prod);
          endcase
        end
        DOT: if (step == 3'd0) dd <= prod; else dd <= fp_add(dd, prod);
        SCALE: begin
          case (step)
            3'd0:    res_x <= prod;
            3'd1:    res_y <= prod;
            default: ray_direction_out <= '{x: res_x, y: res_y, z: prod};
          endcase
        end
        default: ;
      endcase
    end
  end

  fp_inv_sqrt u_inv_sqrt (
    .clk    (clk_in),
    .rst_n  (rst_in),
    .start  (isq_start),
    .arg    (dd),
    .done   (isq_done),
    .result (inv)
  );

endmodule

// File: tb/tb_ray_generator_folded.sv
// Directed self-checking bench for ray_generator_folded.
module tb_ray_generator_folded;
  import ray_generator_folded_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       valid_in;
  logic [8:0] hcount_in;
  logic [7:0] vcount_in;
  fp          hcount_fp_in, vcount_fp_in;
  vec3        cam_forward_in, ray_direction_out;
  logic       valid_out, ready_out;

  int tests = 0;
  int fails = 0;
  int lat0;

  localparam fp PIX_0   = 32'sd0;
  localparam fp PIX_120 = 32'sd7864320;
  localparam fp PIX_160 = 32'sd10485760;
  localparam int TOL    = 32;

  always #5 clk_in = ~clk_in;

  ray_generator_folded #(
    .DISPLAY_WIDTH  (320),
    .DISPLAY_HEIGHT (240),
    .H_BITS         (9),
    .V_BITS         (8)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .valid_in          (valid_in),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .hcount_fp_in      (hcount_fp_in),
    .vcount_fp_in      (vcount_fp_in),
    .cam_forward_in    (cam_forward_in),
    .ray_direction_out (ray_direction_out),
    .valid_out         (valid_out),
    .ready_out         (ready_out)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_near(input string tag, input longint got, input longint exp, input longint tol);
    longint diff;
    diff = (got > exp) ? got - exp : exp - got;
    tests++;
    assert ((diff <= tol) === 1'b1) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic check_vec(input string tag, input vec3 got, input fp ex, input fp ey, input fp ez);
    check_near({tag, ".x"}, longint'(got.x), longint'(ex), TOL);
    check_near({tag, ".y"}, longint'(got.y), longint'(ey), TOL);
    check_near({tag, ".z"}, longint'(got.z), longint'(ez), TOL);
  endtask

  // Issue one request and wait (bounded) for its result.
  task automatic run(input fp hx, input fp vy, input vec3 f, input bit inject,
                     output int lat, output vec3 res, output bit busy_ok, output bit pulse_ok);
    bit seen;
    seen    = 1'b0;
    busy_ok = 1'b1;
    lat     = 0;
    res     = '0;
    hcount_fp_in   = hx;
    vcount_fp_in   = vy;
    hcount_in      = 9'(hx >>> 16);
    vcount_in      = 8'(vy >>> 16);
    cam_forward_in = f;
    valid_in       = 1'b1;
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk_in);
      if (valid_out) begin
        seen = 1'b1;
        res  = ray_direction_out;
      end else begin
        if (ready_out) busy_ok = 1'b0;
        valid_in = inject && (lat == 4);
        if (inject && lat == 4) begin
          hcount_fp_in = PIX_160;
          vcount_fp_in = PIX_0;
        end
        @(posedge clk_in);
        lat++;
      end
    end
    @(negedge clk_in);
    pulse_ok = seen && !valid_out && ready_out;
  endtask

  initial begin
    int   lat;
    vec3  res;
    bit   busy_ok, pulse_ok;
    int   seen;
    longint norm;
    vec3  f_z, f_x;

    f_z = '{x: 32'sd0, y: 32'sd0, z: FP_ONE};
    f_x = '{x: FP_ONE, y: 32'sd0, z: 32'sd0};

    rst_in = 1'b1; valid_in = 1'b0;
    hcount_in = '0; vcount_in = '0;
    hcount_fp_in = '0; vcount_fp_in = '0; cam_forward_in = '0;
    #1 rst_in = 1'b0;
    #2;
    check_eq("reset_ready", longint'(ready_out), 1);
    check_eq("reset_valid", longint'(valid_out), 0);
    check_eq("reset_dir_x", longint'(ray_direction_out.x), 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    // Centre pixel looks straight down f.
    run(PIX_160, PIX_120, f_z, 1'b0, lat, res, busy_ok, pulse_ok);
    lat0 = lat;
    check_eq("lat_bound", longint'(lat <= 64), 1);
    check_vec("center", res, 32'sd0, 32'sd0, 32'sd65536);
    check_eq("center_busy", longint'(busy_ok), 1);
    check_eq("center_pulse", longint'(pulse_ok), 1);

    // Left edge, issued back-to-back in the first IDLE cycle.
    run(PIX_0, PIX_120, f_z, 1'b0, lat, res, busy_ok, pulse_ok);
    check_eq("left_lat", lat, lat0);
    check_vec("left", res, -32'sd36353, 32'sd0, 32'sd54532);
    check_eq("left_pulse", longint'(pulse_ok), 1);

    // Top edge.
    run(PIX_160, PIX_0, f_z, 1'b0, lat, res, busy_ok, pulse_ok);
    check_eq("top_lat", lat, lat0);
    check_vec("top", res, 32'sd0, 32'sd29307, 32'sd58615);
    check_eq("top_busy", longint'(busy_ok), 1);

    // Camera facing +x.
    run(PIX_0, PIX_120, f_x, 1'b0, lat, res, busy_ok, pulse_ok);
    check_eq("fx_lat", lat, lat0);
    check_vec("fx", res, 32'sd54532, 32'sd0, 32'sd36353);
    norm = (longint'(res.x) * res.x + longint'(res.y) * res.y + longint'(res.z) * res.z) >>> 16;
    check_near("fx_norm", norm, 65536, 64);

    // Request asserted mid-computation must be ignored.
    run(PIX_0, PIX_120, f_z, 1'b1, lat, res, busy_ok, pulse_ok);
    check_eq("inject_lat", lat, lat0);
    check_vec("inject", res, -32'sd36353, 32'sd0, 32'sd54532);
    check_eq("inject_pulse", longint'(pulse_ok), 1);

    // Reset in the middle of a computation discards it.
    hcount_fp_in = PIX_0; vcount_fp_in = PIX_0; cam_forward_in = f_z;
    valid_in = 1'b1;
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    repeat (10) @(negedge clk_in);
    check_eq("midrun_busy", longint'(ready_out), 0);
    rst_in = 1'b0;
    #1;
    check_eq("midreset_ready", longint'(ready_out), 1);
    check_eq("midreset_valid", longint'(valid_out), 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk_in);
      if (valid_out) seen++;
    end
    check_eq("no_valid_after_reset", seen, 0);

    run(PIX_160, PIX_0, f_z, 1'b0, lat, res, busy_ok, pulse_ok);
    check_eq("post_reset_lat", lat, lat0);
    check_vec("post_reset", res, 32'sd0, 32'sd29307, 32'sd58615);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
